// File: rtl/aes128_key_expand_seq.sv
// ============================================================================
// aes128_key_expand_seq
// ----------------------------------------------------------------------------
// Sequential AES-128 key schedule generator.
//
// The block latches a 128-bit cipher key when a start is accepted. It then
// presents round keys 0..10 one at a time on a valid/ready handshake.
// A single SubWord unit (four byte S-boxes) works on RotWord(w3) of the
// round key currently held in the output register. That unit produces the
// next round key combinationally, and the next key is registered when the
// consumer accepts the current one.
//
// Ports
//   clk           in   1    rising-edge clock
//   rst           in   1    synchronous, active-high reset
//   start_in      in   1    expansion request, sampled only while idle
//   key_in        in   128  cipher key, w0 = key_in[127:96], byte0 = [127:120]
//   rk_out        out  128  current round key, same ordering as key_in
//   round_out     out  4    round index of rk_out, 0..10
//   rk_valid_out  out  1    rk_out / round_out are valid
//   rk_ready_in   in   1    consumer accepts rk_out on rk_valid_out & rk_ready_in
//   busy_out      out  1    high from start acceptance until the round-10 handshake
//   done_out      out  1    one-cycle pulse after the round-10 handshake
//
// Every output comes straight from a register. There is no combinational
// path from start_in or rk_ready_in to any output.
// ============================================================================
module aes128_key_expand_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   round_out,
    output logic         rk_valid_out,
    input  logic         rk_ready_in,
    output logic         busy_out,
    output logic         done_out
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Forward AES S-box, entry 0 in the most significant byte.
    // Each row holds entries 16*k .. 16*k+15.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Single-byte S-box lookup. The entry for index b starts at bit 2047 - 8*b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] msb;
        msb  = 11'd2047 - {b, 3'b000};
        sbox = SBOX_TABLE[msb -: 8];
    endfunction

    // SubWord: four independent S-box lookups.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant, indexed by the round being left.
    // Round 10 never produces a next key, so its value does not matter.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t         r_state;
    logic [127:0]   r_rk;
    logic [3:0]     r_round;
    logic           r_valid;
    logic           r_busy;
    logic           r_done;

    logic [31:0]    w_w0;
    logic [31:0]    w_w1;
    logic [31:0]    w_w2;
    logic [31:0]    w_w3;
    logic [31:0]    w_rot;
    logic [31:0]    w_t;
    logic [31:0]    w_n0;
    logic [31:0]    w_n1;
    logic [31:0]    w_n2;
    logic [31:0]    w_n3;
    logic [127:0]   w_next_key;
    logic           w_handshake;

    // Next round key, computed only from the registered current round key.
    assign w_w0       = r_rk[127:96];
    assign w_w1       = r_rk[95:64];
    assign w_w2       = r_rk[63:32];
    assign w_w3       = r_rk[31:0];
    assign w_rot      = {w_w3[23:0], w_w3[31:24]};
    assign w_t        = sub_word(w_rot) ^ {rcon(r_round), 24'h000000};
    assign w_n0       = w_w0 ^ w_t;
    assign w_n1       = w_w1 ^ w_n0;
    assign w_n2       = w_w2 ^ w_n1;
    assign w_n3       = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    assign w_handshake = r_valid & rk_ready_in;

    // Control FSM and output registers. Reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rk    <= 128'h0;
            r_round <= 4'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // done_out is a single-cycle pulse unless the branch below sets it.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        // key_in is sampled here and nowhere else.
                        r_state <= ST_EMIT;
                        r_rk    <= key_in;
                        r_round <= 4'd0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (w_handshake) begin
                        if (r_round == LAST_ROUND) begin
                            // rk_out keeps the final key. Only valid drops.
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_rk    <= w_next_key;
                            r_round <= r_round + 4'd1;
                        end
                    end else begin
                        // Backpressure: hold the key and the index unchanged.
                        r_state <= ST_EMIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rk_out       = r_rk;
    assign round_out    = r_round;
    assign rk_valid_out = r_valid;
    assign busy_out     = r_busy;
    assign done_out     = r_done;

endmodule
